// File: rtl/fdct_pkg.sv
// Shared constants and helpers for the 1-D FDCT row/column datapath stages.
package fdct_pkg;

  localparam int DCT_WIDTH     = 8;
  localparam int DCT_SHIFT     = 7;
  localparam int DCT_OUT_WIDTH = 12;

  // Accumulator width: full product width plus growth for summing terms.
  function automatic int acc_width(input int width, input int terms);
    return 2 * width + $clog2(terms);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int                 out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fdct_mac_accum_param_mult.sv
// Combinational signed multiplier used ahead of the MAC product register.
module param_mult #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/fdct_mac_accum.sv
// FDCT multiply-accumulate stage: registered products summed TERMS at a time,
// then rounded, scaled and saturated into a valid/ready coefficient stream.
module fdct_mac_accum
  import fdct_pkg::*;
#(
  parameter int WIDTH     = DCT_WIDTH,
  parameter int TERMS     = 8,
  parameter int SHIFT     = DCT_SHIFT,
  parameter int OUT_WIDTH = DCT_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     in_sample,
  input  logic signed [WIDTH-1:0]     in_coef,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int ACC_W   = acc_width(WIDTH, TERMS);
  localparam int CNT_W   = $clog2(TERMS);
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);
  localparam logic signed [ACC_W:0] RND_ADD =
    (SHIFT > 0) ? (ACC_W + 1)'(64'd1 << RND_POS) : '0;

  logic [CNT_W-1:0]            in_cnt;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [2*WIDTH-1:0]   p_reg;
  logic                        p_vld;
  logic                        p_last;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     sum;
  logic signed [ACC_W:0]       rnd_full;
  logic signed [ACC_W:0]       shifted;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                        stall;
  logic                        consume;
  logic                        xfer;
  logic                        load;

  param_mult #(.WIDTH(WIDTH)) u_mult (
    .a (in_sample),
    .b (in_coef),
    .p (prod)
  );

  // Only a last term with nowhere to put its result blocks the pipe.
  assign stall    = p_vld && p_last && out_valid && !out_ready;
  assign consume  = p_vld && !stall;
  assign in_ready = !stall;
  assign xfer     = in_valid && in_ready;
  assign load     = consume && p_last;

  assign sum      = acc + {{(ACC_W - 2*WIDTH){p_reg[2*WIDTH-1]}}, p_reg};
  assign rnd_full = {sum[ACC_W-1], sum} + RND_ADD;
  assign shifted  = rnd_full >>> SHIFT;
  assign sat_val  = OUT_WIDTH'(sat_signed(64'(shifted), OUT_WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt    <= '0;
      p_reg     <= '0;
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (xfer) begin
        p_reg  <= prod;
        p_vld  <= 1'b1;
        p_last <= (in_cnt == LAST_CNT);
        in_cnt <= (in_cnt == LAST_CNT) ? '0 : in_cnt + 1'b1;
      end else if (consume) begin
        p_vld <= 1'b0;
      end

      if (consume && !p_last) begin
        acc <= sum;
      end

      if (load) begin
        acc       <= '0;
        out_data  <= sat_val;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fdct_mac_accum.sv
// Self-checking bench for fdct_mac_accum: scoreboard on the 12-bit instance,
// direct checks on a 10-bit instance for saturation.
module tb_fdct_mac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic signed [7:0] in_sample, in_coef;
  logic              in_valid, in_ready;
  logic signed [11:0] out_data;
  logic              out_valid, out_ready;

  logic signed [7:0] s_sample, s_coef;
  logic              s_valid, s_in_ready;
  logic signed [9:0] s_out_data;
  logic              s_out_valid;
  logic              s_out_ready;

  fdct_mac_accum #(.WIDTH(8), .TERMS(8), .SHIFT(7), .OUT_WIDTH(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_sample (in_sample),
    .in_coef   (in_coef),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  fdct_mac_accum #(.WIDTH(8), .TERMS(8), .SHIFT(7), .OUT_WIDTH(10)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_sample (s_sample),
    .in_coef   (s_coef),
    .in_valid  (s_valid),
    .in_ready  (s_in_ready),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready)
  );

  typedef struct {
    int s;
    int c;
    int exp;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;
  int stall_waits = 0;
  int exp_q[$];
  int mon_exp;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: round half up at 2^-7, then clamp to out_w bits.
  function automatic int model(input longint sum, input int out_w);
    longint r, hi, lo;
    r  = (sum + 64) >>> 7;
    hi = (longint'(1) << (out_w - 1)) - 1;
    lo = -(longint'(1) << (out_w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got %0d, expected no result", $signed(out_data));
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", int'($signed(out_data)), mon_exp);
      end
    end
  end

  task automatic send(input int s, input int c);
    int budget;
    budget = 0;
    @(negedge clk);
    in_sample = 8'(s);
    in_coef   = 8'(c);
    in_valid  = 1'b1;
    while (!in_ready && budget < 200) begin
      stall_waits++;
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_sat(input string name, input int s, input int c, input int exp);
    int budget;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_sample = 8'(s);
      s_coef   = 8'(c);
      s_valid  = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
    end
    budget = 0;
    while (!s_out_valid && budget < 10) begin
      @(posedge clk);
      #1 budget++;
    end
    check({name, "_valid"}, int'(s_out_valid), 1);
    check(name, int'($signed(s_out_data)), exp);
    @(posedge clk);
  endtask

  vec_t tbl[7];
  int   rs[8];
  int   rc[8];
  longint rsum;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{s: 64,   c: 2,    exp: 8};
    tbl[1] = '{s: 127,  c: -128, exp: -1016};
    tbl[2] = '{s: -128, c: -128, exp: 1024};
    tbl[3] = '{s: 64,   c: 4,    exp: 16};
    tbl[4] = '{s: -64,  c: 2,    exp: -8};
    tbl[5] = '{s: 100,  c: 100,  exp: 625};
    tbl[6] = '{s: 127,  c: 127,  exp: 1008};

    reset = 1'b1; in_valid = 1'b0; in_sample = '0; in_coef = '0; out_ready = 1'b1;
    s_valid = 1'b0; s_sample = '0; s_coef = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(negedge clk) reset = 1'b0;

    // Nominal block with latency and single-cycle valid checks.
    exp_q.push_back(8);
    for (int i = 0; i < 8; i++) send(64, 2);
    check("lat_not_yet", int'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid", int'(out_valid), 1);
    check("lat_data", int'($signed(out_data)), 8);
    @(posedge clk); #1;
    check("valid_one_cycle", int'(out_valid), 0);
    drain();

    for (int v = 0; v < 7; v++) begin
      exp_q.push_back(tbl[v].exp);
      for (int i = 0; i < 8; i++) send(tbl[v].s, tbl[v].c);
    end
    drain();

    rsum = 0;
    for (int i = 0; i < 8; i++) begin
      rs[i] = int'($urandom_range(0, 255)) - 128;
      rc[i] = int'($urandom_range(0, 255)) - 128;
      rsum += longint'(rs[i] * rc[i]);
    end
    exp_q.push_back(model(rsum, 12));
    for (int i = 0; i < 8; i++) send(rs[i], rc[i]);
    drain();

    // Idle cycles between transfers must not disturb the count.
    exp_q.push_back(8);
    for (int i = 0; i < 8; i++) begin
      send(64, 2);
      @(posedge clk);
    end
    drain();

    // Backpressure: second block's last term must stall until the first result leaves.
    @(posedge clk); #1 out_ready = 1'b0;
    stall_waits = 0;
    exp_q.push_back(8);
    exp_q.push_back(16);
    for (int i = 0; i < 8; i++) send(64, 2);
    for (int i = 0; i < 8; i++) send(64, 4);
    check("bp_no_early_stall", stall_waits, 0);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_held_valid", int'(out_valid), 1);
    check("bp_held_data", int'($signed(out_data)), 8);
    repeat (3) @(posedge clk);
    #1;
    check("bp_stable_data", int'($signed(out_data)), 8);
    check("bp_still_stalled", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_next_valid", int'(out_valid), 1);
    check("bp_next_data", int'($signed(out_data)), 16);
    check("bp_released", int'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_done_valid", int'(out_valid), 0);
    drain();

    // Reset in the middle of a block discards the partial sum and count.
    for (int i = 0; i < 5; i++) send(64, 2);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_in_ready", int'(in_ready), 1);
    check("mid_reset_out_valid", int'(out_valid), 0);
    @(negedge clk) reset = 1'b0;
    exp_q.push_back(0);
    for (int i = 0; i < 8; i++) send(1, 1);
    @(posedge clk); #1;
    check("post_reset_valid", int'(out_valid), 1);
    drain();

    run_sat("sat_pos", -128, -128, 511);
    run_sat("sat_neg", 127, -128, -512);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
